// File: rtl/mac_accum_pe.sv
// Signed multiply-accumulate processing element: a product register stage feeds an
// accumulator that emits one LEN-term dot product per vector with a one-cycle valid pulse.
module mac_accum_pe #(
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 2*N+4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             flush,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN-1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                    state_r;
  logic [CW-1:0]             cnt_r;
  logic signed [2*N-1:0]     p_r;
  logic                      p_valid_r;
  logic                      p_first_r;
  logic                      p_last_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   out_sum_r;
  logic                      out_valid_r;
  logic signed [2*N-1:0]     prod_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic                      last_pair_s;

  // Product of the incoming pair and the running sum fed by the product register.
  always_comb begin
    prod_s      = $signed(a) * $signed(b);
    last_pair_s = (cnt_r == LAST);
    if (p_first_r) begin
      sum_s = ACC_W'(p_r);
    end else begin
      sum_s = acc_r + ACC_W'(p_r);
    end
  end

  // Both pipeline stages and the vector-tracking state; flush outranks new input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      p_r         <= {(2*N){1'b0}};
      p_valid_r   <= 1'b0;
      p_first_r   <= 1'b0;
      p_last_r    <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      out_sum_r   <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      p_valid_r   <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      p_valid_r <= in_valid;
      if (in_valid) begin
        p_r       <= prod_s;
        p_first_r <= (cnt_r == {CW{1'b0}});
        p_last_r  <= last_pair_s;
        cnt_r     <= last_pair_s ? {CW{1'b0}} : cnt_r + CW'(1);
        // With LEN=1 every pair is also the last one, so the FSM never leaves IDLE.
        case (state_r)
          IDLE:    state_r <= last_pair_s ? IDLE : ACC;
          ACC:     state_r <= last_pair_s ? IDLE : ACC;
          default: state_r <= IDLE;
        endcase
      end
      if (p_valid_r) begin
        acc_r <= sum_s;
        if (p_last_r) begin
          out_sum_r <= sum_s;
        end
      end
      out_valid_r <= p_valid_r & p_last_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign busy      = (state_r == ACC) | p_valid_r;

endmodule
